// File: rtl/xpu_pkg.sv
// Shared xpu definitions: 802.11 frame-control field codes, the response
// scheduler state encoding and the CTS duration helper.
package xpu_pkg;

   localparam logic [1:0] TYPE_MGMT = 2'd0;
   localparam logic [1:0] TYPE_CTRL = 2'd1;
   localparam logic [1:0] TYPE_DATA = 2'd2;

   localparam logic [3:0] SUBTYPE_RTS = 4'd11;
   localparam logic [3:0] SUBTYPE_CTS = 4'd12;
   localparam logic [3:0] SUBTYPE_ACK = 4'd13;

   localparam logic RESP_ACK = 1'b0;
   localparam logic RESP_CTS = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_HDR      = 3'd1,
      ST_WAIT_FCS = 3'd2,
      ST_SIFS     = 3'd3,
      ST_REQ      = 3'd4
   } state_t;

   // An AID-form duration (bit 15 set) carries no NAV time, so CTS gets 0.
   function automatic logic [15:0] cts_duration(input logic [15:0] dur, input logic [15:0] sub);
      if (dur[15] || (dur < sub)) return 16'd0;
      return dur - sub;
   endfunction

endpackage

// File: rtl/resp_timer.sv
// Loadable 16-bit down-counter with a zero flag; shared by the SIFS wait
// and the response-ack timeout.
module resp_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] load_val,
   input  logic        dec,
   output logic        zero
);

   logic [15:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != 16'd0)) begin
         count_d = count_q - 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) count_q <= 16'd0;
      else     count_q <= count_d;
   end

   assign zero = (count_q == 16'd0);

endmodule

// File: rtl/rx_resp_scheduler.sv
// Decides whether a received frame needs an ACK/CTS and raises resp_req
// SIFS_CYCLES clocks after the FCS verdict.
module rx_resp_scheduler
   import xpu_pkg::*;
#(
   parameter int unsigned SIFS_CYCLES  = 1600,
   parameter int unsigned RESP_TIMEOUT = 200,
   parameter int unsigned DUR_SUB      = 44
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [47:0] self_mac,
   input  logic [31:0] FC_DI,
   input  logic        FC_DI_valid,
   input  logic [47:0] rx_addr,
   input  logic        rx_addr_valid,
   input  logic [47:0] tx_addr,
   input  logic        tx_addr_valid,
   input  logic        rx_start,
   input  logic        fcs_valid,
   input  logic        fcs_ok,
   output logic        resp_req,
   output logic        resp_type,
   output logic [47:0] resp_addr,
   output logic [15:0] resp_duration,
   input  logic        resp_ack,
   output logic [7:0]  resp_drop_cnt,
   output logic [2:0]  dbg_state
);

   // Handshake: resp_req is a level held, with resp_type/addr/duration stable,
   // until resp_ack is sampled high or the timeout expires; resp_ack is ignored
   // while resp_req is low.
   localparam logic [15:0] SIFS_LOAD = 16'(SIFS_CYCLES - 1);
   localparam logic [15:0] TMO_LOAD  = 16'(RESP_TIMEOUT - 1);
   localparam logic [15:0] DUR_SUB_W = 16'(DUR_SUB);

   state_t      state_q, state_d;
   logic [1:0]  ftype_q, ftype_d;
   logic [3:0]  fsub_q, fsub_d;
   logic [15:0] dur_q, dur_d;
   logic        match_q, match_d;
   logic [47:0] tx_addr_q, tx_addr_d;
   logic        resp_req_q, resp_req_d;
   logic        resp_type_q, resp_type_d;
   logic [47:0] resp_addr_q, resp_addr_d;
   logic [15:0] resp_duration_q, resp_duration_d;
   logic [7:0]  drop_cnt_q, drop_cnt_d;
   logic        tmr_load, tmr_dec, tmr_zero;
   logic [15:0] tmr_load_val;
   logic        is_rts, is_ack_able, qualify;
   logic [47:0] tx_addr_eff;
   logic        fc_unused;

   assign fc_unused   = ^{FC_DI[15:8], FC_DI[1:0]};
   assign is_rts      = (ftype_q == TYPE_CTRL) && (fsub_q == SUBTYPE_RTS);
   assign is_ack_able = (ftype_q == TYPE_MGMT) || (ftype_q == TYPE_DATA);
   assign qualify     = fcs_ok && match_q && (is_ack_able || is_rts);
   // tx_addr may still be arriving in the same cycle as the FCS verdict.
   assign tx_addr_eff = tx_addr_valid ? tx_addr : tx_addr_q;

   resp_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   always_comb begin
      state_d         = state_q;
      ftype_d         = ftype_q;
      fsub_d          = fsub_q;
      dur_d           = dur_q;
      match_d         = match_q;
      tx_addr_d       = tx_addr_q;
      resp_req_d      = resp_req_q;
      resp_type_d     = resp_type_q;
      resp_addr_d     = resp_addr_q;
      resp_duration_d = resp_duration_q;
      drop_cnt_d      = drop_cnt_q;
      tmr_load        = 1'b0;
      tmr_load_val    = SIFS_LOAD;
      tmr_dec         = 1'b0;
      if (rx_start) begin
         // A new PPDU aborts whatever is pending, including a live request.
         state_d    = ST_HDR;
         resp_req_d = 1'b0;
         match_d    = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_HDR: begin
               if (FC_DI_valid) begin
                  ftype_d = FC_DI[3:2];
                  fsub_d  = FC_DI[7:4];
                  dur_d   = FC_DI[31:16];
               end
               if (tx_addr_valid) tx_addr_d = tx_addr;
               if (rx_addr_valid) begin
                  match_d = (rx_addr == self_mac) && !rx_addr[0];
                  state_d = ST_WAIT_FCS;
               end
            end
            ST_WAIT_FCS: begin
               tx_addr_d = tx_addr_eff;
               if (fcs_valid) begin
                  if (qualify) begin
                     state_d         = ST_SIFS;
                     tmr_load        = 1'b1;
                     tmr_load_val    = SIFS_LOAD;
                     resp_type_d     = is_rts ? RESP_CTS : RESP_ACK;
                     resp_addr_d     = tx_addr_eff;
                     resp_duration_d = is_rts ? cts_duration(dur_q, DUR_SUB_W) : 16'd0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
            ST_SIFS: begin
               if (tmr_zero) begin
                  state_d      = ST_REQ;
                  resp_req_d   = 1'b1;
                  tmr_load     = 1'b1;
                  tmr_load_val = TMO_LOAD;
               end else begin
                  tmr_dec = 1'b1;
               end
            end
            ST_REQ: begin
               if (resp_ack) begin
                  resp_req_d = 1'b0;
                  state_d    = ST_IDLE;
               end else if (tmr_zero) begin
                  resp_req_d = 1'b0;
                  state_d    = ST_IDLE;
                  if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
               end else begin
                  tmr_dec = 1'b1;
               end
            end
            default: begin
               state_d    = ST_IDLE;
               resp_req_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         ftype_q         <= 2'd0;
         fsub_q          <= 4'd0;
         dur_q           <= 16'd0;
         match_q         <= 1'b0;
         tx_addr_q       <= 48'd0;
         resp_req_q      <= 1'b0;
         resp_type_q     <= 1'b0;
         resp_addr_q     <= 48'd0;
         resp_duration_q <= 16'd0;
         drop_cnt_q      <= 8'd0;
      end else begin
         state_q         <= state_d;
         ftype_q         <= ftype_d;
         fsub_q          <= fsub_d;
         dur_q           <= dur_d;
         match_q         <= match_d;
         tx_addr_q       <= tx_addr_d;
         resp_req_q      <= resp_req_d;
         resp_type_q     <= resp_type_d;
         resp_addr_q     <= resp_addr_d;
         resp_duration_q <= resp_duration_d;
         drop_cnt_q      <= drop_cnt_d;
      end
   end

   assign resp_req      = resp_req_q;
   assign resp_type     = resp_type_q;
   assign resp_addr     = resp_addr_q;
   assign resp_duration = resp_duration_q;
   assign resp_drop_cnt = drop_cnt_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_rx_resp_scheduler.sv
// Directed and randomized frames against a frame-level response model for
// rx_resp_scheduler (short SIFS so the 260-drop saturation run stays brief).
module tb_rx_resp_scheduler;
   import xpu_pkg::*;

   localparam int SIFS = 32;
   localparam int TMO  = 200;
   localparam int DSUB = 44;
   localparam logic [47:0] PEER  = 48'h112233445566;
   localparam logic [47:0] PEER2 = 48'h665544332211;
   localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic [47:0] self_mac;
   logic [31:0] FC_DI;
   logic        FC_DI_valid;
   logic [47:0] rx_addr;
   logic        rx_addr_valid;
   logic [47:0] tx_addr;
   logic        tx_addr_valid;
   logic        rx_start;
   logic        fcs_valid;
   logic        fcs_ok;
   logic        resp_req;
   logic        resp_type;
   logic [47:0] resp_addr;
   logic [15:0] resp_duration;
   logic        resp_ack;
   logic [7:0]  resp_drop_cnt;
   logic [2:0]  dbg_state;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int drops_model = 0;
   logic [64:0] exp_q[$];
   int          exp_t_q[$];

   rx_resp_scheduler #(
      .SIFS_CYCLES  (SIFS),
      .RESP_TIMEOUT (TMO),
      .DUR_SUB      (DSUB)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .self_mac      (self_mac),
      .FC_DI         (FC_DI),
      .FC_DI_valid   (FC_DI_valid),
      .rx_addr       (rx_addr),
      .rx_addr_valid (rx_addr_valid),
      .tx_addr       (tx_addr),
      .tx_addr_valid (tx_addr_valid),
      .rx_start      (rx_start),
      .fcs_valid     (fcs_valid),
      .fcs_ok        (fcs_ok),
      .resp_req      (resp_req),
      .resp_type     (resp_type),
      .resp_addr     (resp_addr),
      .resp_duration (resp_duration),
      .resp_ack      (resp_ack),
      .resp_drop_cnt (resp_drop_cnt),
      .dbg_state     (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Frame-level reference: {resp_type, resp_addr, resp_duration}, q=1 if a response is due.
   function automatic logic [64:0] model_resp(input logic [31:0] fc, input logic [47:0] ra,
                                              input logic [47:0] ta, input bit ok, output bit q);
      int ty, st, dur, d;
      bit rts, mine;
      ty   = int'(fc[3:2]);
      st   = int'(fc[7:4]);
      dur  = int'(fc[31:16]);
      rts  = (ty == 1) && (st == 11);
      mine = (ra == self_mac) && (ra[0] == 1'b0);
      q    = ok && mine && ((ty == 0) || (ty == 2) || rts);
      d    = 0;
      if (rts && dur < 32768) d = (dur > DSUB) ? dur - DSUB : 0;
      return {rts, ta, 16'(d)};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_hdr(input logic [31:0] fc, input logic [47:0] ra, input logic [47:0] ta,
                           input bit has_tx);
      rx_start = 1'b1;      tick(); rx_start = 1'b0;
      FC_DI = fc;           FC_DI_valid = 1'b1;   tick(); FC_DI_valid = 1'b0;
      rx_addr = ra;         rx_addr_valid = 1'b1; tick(); rx_addr_valid = 1'b0;
      if (has_tx) begin
         tx_addr = ta;      tx_addr_valid = 1'b1; tick(); tx_addr_valid = 1'b0;
      end
   endtask

   task automatic send_fcs(input bit ok, output int t_exp);
      fcs_ok    = ok;
      fcs_valid = 1'b1;
      t_exp     = cyc + 1 + SIFS;
      tick();
      fcs_valid = 1'b0;
   endtask

   task automatic wait_rise(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (resp_req) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   // ack_at = n: ack during the n-th cycle resp_req is high; 0 = never ack.
   task automatic do_frame(input logic [31:0] fc, input logic [47:0] ra, input logic [47:0] ta,
                           input bit has_tx, input bit ok, input int ack_at);
      bit q, seen;
      logic [64:0] e;
      int t_exp, t_pop, hi;
      send_hdr(fc, ra, ta, has_tx);
      e = model_resp(fc, ra, ta, ok, q);
      send_fcs(ok, t_exp);
      wait_rise(SIFS + 20, seen);
      if (!q) begin
         check("no_resp", 64'(seen), 64'd0);
         check("idle_after_no_resp", 64'(dbg_state), 64'(ST_IDLE));
      end else begin
         exp_q.push_back(e);
         exp_t_q.push_back(t_exp);
         e     = exp_q.pop_front();
         t_pop = exp_t_q.pop_front();
         check("resp_seen", 64'(seen), 64'd1);
         if (seen) begin
            check("rise_time", 64'(cyc), 64'(t_pop));
            check("resp_type", 64'(resp_type), 64'(e[64]));
            check("resp_addr", 64'(resp_addr), 64'(e[63:16]));
            check("resp_duration", 64'(resp_duration), 64'(e[15:0]));
            if (ack_at > 0) begin
               repeat (ack_at - 1) @(negedge clk);
               check("req_held_until_ack", 64'(resp_req), 64'd1);
               resp_ack = 1'b1;
               @(posedge clk); #1;
               resp_ack = 1'b0;
               @(negedge clk);
               check("req_low_after_ack", 64'(resp_req), 64'd0);
               check("idle_after_ack", 64'(dbg_state), 64'(ST_IDLE));
               check("drop_cnt_after_ack", 64'(resp_drop_cnt), 64'(drops_model));
            end else begin
               hi = 1;
               while (resp_req && hi < TMO + 10) begin
                  @(negedge clk);
                  if (resp_req) hi++;
               end
               if (drops_model < 255) drops_model++;
               check("req_width_timeout", 64'(hi), 64'(TMO));
               check("drop_cnt", 64'(resp_drop_cnt), 64'(drops_model));
               check("idle_after_drop", 64'(dbg_state), 64'(ST_IDLE));
            end
         end
      end
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [7:0]  lows[6];
      logic [31:0] fc;
      logic [47:0] ra;
      logic [15:0] dur;
      int t_exp, sel, ack_at;
      bit seen;

      lows = '{8'h08, 8'h00, 8'hB4, 8'hC4, 8'hD4, 8'h0C};
      rst = 1'b1;
      self_mac = 48'h0F0E0D0C0B0A;
      FC_DI = '0; FC_DI_valid = 1'b0;
      rx_addr = '0; rx_addr_valid = 1'b0;
      tx_addr = '0; tx_addr_valid = 1'b0;
      rx_start = 1'b0; fcs_valid = 1'b0; fcs_ok = 1'b0; resp_ack = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      check("rst_resp_req", 64'(resp_req), 64'd0);
      check("rst_resp_type", 64'(resp_type), 64'd0);
      check("rst_resp_addr", 64'(resp_addr), 64'd0);
      check("rst_resp_duration", 64'(resp_duration), 64'd0);
      check("rst_drop_cnt", 64'(resp_drop_cnt), 64'd0);
      check("rst_state", 64'(dbg_state), 64'(ST_IDLE));

      // Unicast data -> ACK, acked on third request clock
      do_frame(32'h0000_0008, self_mac, PEER, 1'b1, 1'b1, 3);
      // RTS variants -> CTS with derived durations
      do_frame(32'h0100_00B4, self_mac, PEER, 1'b1, 1'b1, 1);
      do_frame(32'h001E_00B4, self_mac, PEER, 1'b1, 1'b1, 2);
      do_frame(32'h002C_00B4, self_mac, PEER2, 1'b1, 1'b1, 1);
      do_frame(32'h8100_00B4, self_mac, PEER, 1'b1, 1'b1, 1);
      do_frame(32'h7FFF_00B4, self_mac, PEER2, 1'b1, 1'b1, 4);
      // Non-qualifying frames
      do_frame(32'h0000_0008, BCAST, PEER, 1'b1, 1'b1, 1);
      do_frame(32'h0000_0008, self_mac, PEER, 1'b1, 1'b0, 1);
      do_frame(32'h0000_00D4, self_mac, PEER, 1'b0, 1'b1, 1);
      do_frame(32'h0000_00C4, self_mac, PEER, 1'b0, 1'b1, 1);
      do_frame(32'h0000_000C, self_mac, PEER, 1'b1, 1'b1, 1);
      // Own address with the group bit set never matches
      self_mac = 48'h0A0B0C0D0E0F;
      do_frame(32'h0000_0008, self_mac, PEER, 1'b1, 1'b1, 1);
      self_mac = 48'h0F0E0D0C0B0A;

      // Timeout, then ack arriving on the timeout cycle
      do_frame(32'h0000_0008, self_mac, PEER, 1'b1, 1'b1, 0);
      do_frame(32'h0000_0008, self_mac, PEER, 1'b1, 1'b1, TMO);

      // rx_start halfway through SIFS aborts; the next frame parses normally
      send_hdr(32'h0000_0008, self_mac, PEER, 1'b1);
      send_fcs(1'b1, t_exp);
      repeat (SIFS / 2) tick();
      check("abort_sifs_no_req", 64'(resp_req), 64'd0);
      do_frame(32'h0000_0008, self_mac, PEER2, 1'b1, 1'b1, 2);

      // rx_start coincident with fcs_valid: verdict ignored
      send_hdr(32'h0000_0008, self_mac, PEER, 1'b1);
      rx_start = 1'b1; fcs_ok = 1'b1; fcs_valid = 1'b1;
      tick();
      rx_start = 1'b0; fcs_valid = 1'b0;
      wait_rise(SIFS + 20, seen);
      check("start_fcs_same_no_resp", 64'(seen), 64'd0);
      check("start_fcs_same_state", 64'(dbg_state), 64'(ST_HDR));

      // rx_start while the request is live
      send_hdr(32'h0000_0008, self_mac, PEER, 1'b1);
      send_fcs(1'b1, t_exp);
      wait_rise(SIFS + 20, seen);
      check("abort_req_seen", 64'(seen), 64'd1);
      rx_start = 1'b1;
      @(posedge clk); #1;
      rx_start = 1'b0;
      @(negedge clk);
      check("abort_req_low", 64'(resp_req), 64'd0);
      check("abort_req_state", 64'(dbg_state), 64'(ST_HDR));
      check("abort_req_no_drop", 64'(resp_drop_cnt), 64'(drops_model));
      do_frame(32'h0100_00B4, self_mac, PEER2, 1'b1, 1'b1, 1);

      // fcs_valid and resp_ack in IDLE are ignored
      resp_ack = 1'b1; fcs_ok = 1'b1; fcs_valid = 1'b1;
      tick();
      fcs_valid = 1'b0;
      repeat (SIFS + 5) tick();
      resp_ack = 1'b0;
      check("idle_fcs_ignored_req", 64'(resp_req), 64'd0);
      check("idle_fcs_ignored_state", 64'(dbg_state), 64'(ST_IDLE));
      check("idle_ack_no_drop", 64'(resp_drop_cnt), 64'(drops_model));

      // Randomized frames
      for (int i = 0; i < 30; i++) begin
         sel = $urandom_range(0, 5);
         dur = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 100)) : 16'($urandom_range(0, 65535));
         fc  = {dur, 8'h00, lows[sel]};
         case ($urandom_range(0, 3))
            0, 1:    ra = self_mac;
            2:       ra = BCAST;
            default: ra = self_mac ^ 48'h0000_0000_0100;
         endcase
         ack_at = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 6);
         do_frame(fc, ra, {16'h5A00, 32'($urandom)}, !(sel == 3 || sel == 4),
                  ($urandom_range(0, 3) != 0), ack_at);
      end

      // Drop counter saturation
      for (int i = 0; i < 260; i++) begin
         do_frame(32'h0000_0008, self_mac, PEER, 1'b1, 1'b1, 0);
      end
      check("drop_cnt_saturated", 64'(resp_drop_cnt), 64'd255);

      // Reset while the request is live clears everything
      send_hdr(32'h0000_0008, self_mac, PEER, 1'b1);
      send_fcs(1'b1, t_exp);
      wait_rise(SIFS + 20, seen);
      check("rst_req_seen", 64'(seen), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      drops_model = 0;
      @(negedge clk);
      check("rst_mid_req", 64'(resp_req), 64'd0);
      check("rst_mid_drop_cnt", 64'(resp_drop_cnt), 64'(drops_model));
      check("rst_mid_state", 64'(dbg_state), 64'(ST_IDLE));
      check("rst_mid_addr", 64'(resp_addr), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
